pong_frame_ctrl: RTL and testbench
==================================

PONG_FRAME_CTRL -- requirements
Module: pong_frame_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- H_DISP, 640: visible width.
- V_DISP, 480: visible height.
- WALL_X_L, 32: wall left column.
- WALL_X_R, 35: wall right column.
- PAD_X_L, 600: paddle left column.
- PAD_X_R, 603: paddle right column.
- PAD_H, 72: paddle height.
- PAD_V, 4: paddle step per frame.
- BALL_SZ, 8: ball edge.
- BALL_V, 2: ball speed per axis.

REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1: single system clock.
- reset, in, 1: synchronous, active-high reset.
- p_tick, in, 1: pixel enable from vga_sync.
- video_on, in, 1: visible area flag.
- pixel_x, in, 10: current column.
- pixel_y, in, 10: current row.
- btn_up, in, 1: paddle up request.
- btn_down, in, 1: paddle down request.
- rgb, out, 12: pixel colour, 4:4:4.
- ball_x, out, 10: ball left column.
- ball_y, out, 10: ball top row.
- pad_y, out, 10: paddle top row.
- busy, out, 1: update FSM active.
- hit, out, 1: one-clk paddle-hit pulse.
- miss, out, 1: one-clk miss pulse.
- miss_cnt, out, 4: miss counter.

Function
REQ-003 refr_tick SHALL be an internal one-clk pulse, asserted when p_tick=1, pixel_x=0 and pixel_y=V_DISP+1.
REQ-004 The FSM SHALL have the states IDLE, PAD, BALL and CHK:
- IDLE goes to PAD on refr_tick.
- PAD, BALL and CHK each last exactly one clk.
- CHK returns to IDLE.
- busy=1 in every state except IDLE.
- refr_tick arriving while busy=1 SHALL be ignored.
REQ-005 PAD SHALL move the paddle as follows:
- btn_up only: pad_y becomes max(pad_y-PAD_V, 0).
- btn_down only: pad_y becomes min(pad_y+PAD_V, V_DISP-PAD_H), i.e. 408.
- Both buttons or neither: pad_y is held.
REQ-006 BALL SHALL add the signed velocities dx and dy (each ±BALL_V) to ball_x and ball_y.
REQ-007 CHK SHALL evaluate the updated position, checking each axis independently, in this order:
- ball_y<=1: dy=+BALL_V.
- ball_y+BALL_SZ>=V_DISP-1: dy=-BALL_V.
- ball_x<=WALL_X_R: dx=+BALL_V.
- Paddle hit: when PAD_X_L<=ball_x+BALL_SZ-1<=PAD_X_R, ball_y+BALL_SZ-1>=pad_y and ball_y<=pad_y+PAD_H-1, then dx=-BALL_V and hit is pulsed.
- Otherwise, if ball_x>H_DISP-BALL_SZ: miss. Set ball to (320,240), dx=dy=+BALL_V, pulse miss.
REQ-008 hit and miss SHALL never assert in the same clk; hit takes priority.
REQ-009 rgb SHALL be registered and updated only on p_tick, one p_tick after the pixel coordinates are presented. It is selected by fixed priority:
- video_on=0: 12'h000.
- Pixel inside the ball square: 12'hF00.
- Pixel inside the paddle: 12'h0F0.
- Pixel in the wall columns: 12'h00F.
- Otherwise: 12'hFFF.
REQ-010 Position registers SHALL change only in PAD, BALL and CHK, never during visible scan-out.
REQ-011 All arithmetic SHALL be 11-bit internally, so that subtraction and addition never wrap.

Reset
REQ-012 While reset=1 at a clk edge, the block SHALL set:
- FSM state to IDLE.
- ball_x=320, ball_y=240.
- dx=dy=+BALL_V.
- pad_y=204.
- rgb=0, busy=0, hit=0, miss=0, miss_cnt=0.
REQ-013 A reset asserted during PAD, BALL or CHK SHALL abandon the update; no partial position is retained.

Configuration
REQ-014 With macro PONG_MISS_CNT_EN defined, miss_cnt SHALL increment on each miss and saturate at 15.
REQ-015 Without PONG_MISS_CNT_EN, miss_cnt SHALL be held at 0 and the counter logic SHALL be absent. All other behaviour is identical.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Reset, then one refr_tick with no buttons -> busy high for 3 clks; ball becomes (322,242); pad_y stays 204.
- pad_y=2, btn_up held for 1 frame -> pad_y=0; second frame -> pad_y=0.
- Ball placed at (592,240), dx=+2, pad_y=204, one frame -> ball_x+7=601, hit=1 for 1 clk, dx=-2.
- pad_y=0, ball at (632,300) moving +x -> miss=1; ball (320,240); miss_cnt=1 with PONG_MISS_CNT_EN, 0 without.
- pixel (324,244), video_on=1, ball at (320,240), p_tick -> next p_tick rgb=F00; video_on=0 -> rgb=000.
- reset asserted in BALL state -> next clk IDLE with reset values; no hit or miss pulse.

Source files
------------

// File: rtl/pong_frame_ctrl.sv
// Pong frame controller: once-per-frame paddle/ball update FSM and registered pixel colour.
// Optional PONG_MISS_CNT_EN builds a saturating 4-bit miss counter; otherwise miss_cnt is 0.
module pong_frame_ctrl #(
    parameter int unsigned H_DISP   = 640,
    parameter int unsigned V_DISP   = 480,
    parameter int unsigned WALL_X_L = 32,
    parameter int unsigned WALL_X_R = 35,
    parameter int unsigned PAD_X_L  = 600,
    parameter int unsigned PAD_X_R  = 603,
    parameter int unsigned PAD_H    = 72,
    parameter int unsigned PAD_V    = 4,
    parameter int unsigned BALL_SZ  = 8,
    parameter int unsigned BALL_V   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic [11:0] rgb,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output logic [9:0]  pad_y,
    output logic        busy,
    output logic        hit,
    output logic        miss,
    output logic [3:0]  miss_cnt
);

    localparam logic [10:0] HDisp  = 11'(H_DISP);
    localparam logic [10:0] VDisp  = 11'(V_DISP);
    localparam logic [10:0] WallXL = 11'(WALL_X_L);
    localparam logic [10:0] WallXR = 11'(WALL_X_R);
    localparam logic [10:0] PadXL  = 11'(PAD_X_L);
    localparam logic [10:0] PadXR  = 11'(PAD_X_R);
    localparam logic [10:0] PadH   = 11'(PAD_H);
    localparam logic [10:0] PadV   = 11'(PAD_V);
    localparam logic [10:0] BallSz = 11'(BALL_SZ);
    localparam logic [10:0] BallV  = 11'(BALL_V);
    localparam logic [10:0] PosMax = 11'd1023;
    localparam logic [10:0] PadMax = 11'(V_DISP - PAD_H);
    localparam logic [9:0]  BallX0 = 10'(H_DISP / 2);
    localparam logic [9:0]  BallY0 = 10'(V_DISP / 2);
    localparam logic [9:0]  PadY0  = 10'((V_DISP - PAD_H) / 2);

    typedef enum logic [1:0] {StIdle, StPad, StBall, StChk} state_e;

    state_e      state_q;
    logic [9:0]  ball_x_q, ball_y_q, pad_y_q;
    logic        dx_neg_q, dy_neg_q;
    logic        busy_q, hit_q, miss_q;
    logic [11:0] rgb_q;

    logic        refr_tick;
    logic [10:0] bx, by, pad, px, py;
    logic [10:0] pad_up, pad_dn_sum, pad_dn, pad_nxt;
    logic [10:0] bx_sum, by_sum, bx_nxt, by_nxt;
    logic [10:0] ball_r, ball_b;
    logic        top_hit, bot_hit, wall_hit, pad_hit, out_right;
    logic        in_ball, in_pad, in_wall;
    logic [11:0] rgb_d;

    assign refr_tick = p_tick && (pixel_x == 10'd0) && ({1'b0, pixel_y} == VDisp + 11'd1);

    assign bx  = {1'b0, ball_x_q};
    assign by  = {1'b0, ball_y_q};
    assign pad = {1'b0, pad_y_q};
    assign px  = {1'b0, pixel_x};
    assign py  = {1'b0, pixel_y};

    // All position arithmetic is 11-bit and clamped, so nothing can wrap.
    always_comb begin
        pad_up     = (pad >= PadV) ? pad - PadV : 11'd0;
        pad_dn_sum = pad + PadV;
        pad_dn     = (pad_dn_sum > PadMax) ? PadMax : pad_dn_sum;
        if (btn_up && !btn_down) begin
            pad_nxt = pad_up;
        end else if (btn_down && !btn_up) begin
            pad_nxt = pad_dn;
        end else begin
            pad_nxt = pad;
        end

        bx_sum = bx + BallV;
        by_sum = by + BallV;
        if (dx_neg_q) begin
            bx_nxt = (bx >= BallV) ? bx - BallV : 11'd0;
        end else begin
            bx_nxt = (bx_sum > PosMax) ? PosMax : bx_sum;
        end
        if (dy_neg_q) begin
            by_nxt = (by >= BallV) ? by - BallV : 11'd0;
        end else begin
            by_nxt = (by_sum > PosMax) ? PosMax : by_sum;
        end
    end

    // Collision terms, evaluated on the already-moved ball while in StChk.
    always_comb begin
        ball_r    = bx + BallSz - 11'd1;
        ball_b    = by + BallSz - 11'd1;
        top_hit   = by <= 11'd1;
        bot_hit   = (by + BallSz) >= (VDisp - 11'd1);
        wall_hit  = bx <= WallXR;
        pad_hit   = (ball_r >= PadXL) && (ball_r <= PadXR) &&
                    (ball_b >= pad) && (by <= pad + PadH - 11'd1);
        out_right = bx > (HDisp - BallSz);
    end

`ifdef PONG_MISS_CNT_EN
    logic [3:0] miss_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign miss_cnt = 4'd0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            ball_x_q <= BallX0;
            ball_y_q <= BallY0;
            pad_y_q  <= PadY0;
            dx_neg_q <= 1'b0;
            dy_neg_q <= 1'b0;
            busy_q   <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
`ifdef PONG_MISS_CNT_EN
            miss_cnt_q <= 4'd0;
`endif
        end else begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (refr_tick) begin
                        state_q <= StPad;
                        busy_q  <= 1'b1;
                    end
                end
                StPad: begin
                    pad_y_q <= pad_nxt[9:0];
                    state_q <= StBall;
                end
                StBall: begin
                    ball_x_q <= bx_nxt[9:0];
                    ball_y_q <= by_nxt[9:0];
                    state_q  <= StChk;
                end
                StChk: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    if (top_hit) begin
                        dy_neg_q <= 1'b0;
                    end else if (bot_hit) begin
                        dy_neg_q <= 1'b1;
                    end
                    // Hit wins over miss; a miss also overrides the vertical bounce.
                    if (wall_hit) begin
                        dx_neg_q <= 1'b0;
                    end else if (pad_hit) begin
                        dx_neg_q <= 1'b1;
                        hit_q    <= 1'b1;
                    end else if (out_right) begin
                        ball_x_q <= BallX0;
                        ball_y_q <= BallY0;
                        dx_neg_q <= 1'b0;
                        dy_neg_q <= 1'b0;
                        miss_q   <= 1'b1;
`ifdef PONG_MISS_CNT_EN
                        if (miss_cnt_q != 4'hF) begin
                            miss_cnt_q <= miss_cnt_q + 4'd1;
                        end
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        in_ball = (px >= bx) && (px <= bx + BallSz - 11'd1) &&
                  (py >= by) && (py <= by + BallSz - 11'd1);
        in_pad  = (px >= PadXL) && (px <= PadXR) &&
                  (py >= pad) && (py <= pad + PadH - 11'd1);
        in_wall = (px >= WallXL) && (px <= WallXR);
        if (!video_on) begin
            rgb_d = 12'h000;
        end else if (in_ball) begin
            rgb_d = 12'hF00;
        end else if (in_pad) begin
            rgb_d = 12'h0F0;
        end else if (in_wall) begin
            rgb_d = 12'h00F;
        end else begin
            rgb_d = 12'hFFF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= 12'h000;
        end else if (p_tick) begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb    = rgb_q;
    assign ball_x = ball_x_q;
    assign ball_y = ball_y_q;
    assign pad_y  = pad_y_q;
    assign busy   = busy_q;
    assign hit    = hit_q;
    assign miss   = miss_q;

endmodule

// File: tb/tb_pong_frame_ctrl.sv
// Directed bench for pong_frame_ctrl: default instance plus a PAD_V=202 instance for clamp and miss.
module tb_pong_frame_ctrl;

    logic        clk;
    logic        reset;
    logic        p_tick, p_tick2;
    logic        video_on;
    logic [9:0]  pixel_x, pixel_y;
    logic        btn_up, btn_down, btn2_up, btn2_down;

    logic [11:0] rgb, rgb2;
    logic [9:0]  ball_x, ball_y, pad_y, ball_x2, ball_y2, pad_y2;
    logic        busy, hit, miss, busy2, hit2, miss2;
    logic [3:0]  miss_cnt, miss_cnt2;

`ifdef PONG_MISS_CNT_EN
    localparam int ExpMissCnt = 1;
`else
    localparam int ExpMissCnt = 0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pong_frame_ctrl dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .btn_up(btn_up), .btn_down(btn_down),
        .rgb(rgb), .ball_x(ball_x), .ball_y(ball_y), .pad_y(pad_y),
        .busy(busy), .hit(hit), .miss(miss), .miss_cnt(miss_cnt)
    );

    pong_frame_ctrl #(.PAD_V(202)) dut2 (
        .clk(clk), .reset(reset), .p_tick(p_tick2), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .btn_up(btn2_up), .btn_down(btn2_down),
        .rgb(rgb2), .ball_x(ball_x2), .ball_y(ball_y2), .pad_y(pad_y2),
        .busy(busy2), .hit(hit2), .miss(miss2), .miss_cnt(miss_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One refresh tick held for four clocks; counts busy/hit/miss cycles over the next six.
    task automatic frame(input bit which, output int nbusy, output int nhit, output int nmiss);
        nbusy = 0;
        nhit  = 0;
        nmiss = 0;
        @(negedge clk);
        pixel_x  = 10'd0;
        pixel_y  = 10'd481;
        video_on = 1'b0;
        if (which) p_tick2 = 1'b1;
        else p_tick = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 3) begin
                p_tick  = 1'b0;
                p_tick2 = 1'b0;
            end
            if (which) begin
                nbusy += int'(busy2);
                nhit  += int'(hit2);
                nmiss += int'(miss2);
            end else begin
                nbusy += int'(busy);
                nhit  += int'(hit);
                nmiss += int'(miss);
            end
        end
    endtask

    task automatic pix(input int x, input int y, input bit von, input string tag, input int exp);
        @(negedge clk);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = von;
        p_tick2  = 1'b1;
        @(negedge clk);
        p_tick2 = 1'b0;
        check(tag, int'(rgb2), exp);
    endtask

    initial begin
        int nb, nh, nm, th, tm;
        reset = 1'b1;
        p_tick = 1'b0;
        p_tick2 = 1'b0;
        video_on = 1'b0;
        pixel_x = 10'd0;
        pixel_y = 10'd0;
        btn_up = 1'b0;
        btn_down = 1'b0;
        btn2_up = 1'b0;
        btn2_down = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ball_x", int'(ball_x), 320);
        check("rst_ball_y", int'(ball_y), 240);
        check("rst_pad_y", int'(pad_y), 204);
        check("rst_busy", int'(busy), 0);
        check("rst_hit", int'(hit), 0);
        check("rst_miss", int'(miss), 0);
        check("rst_miss_cnt", int'(miss_cnt), 0);
        check("rst_rgb", int'(rgb), 0);
        reset = 1'b0;

        frame(0, nb, nh, nm);
        check("f1_busy_clks", nb, 3);
        check("f1_ball_x", int'(ball_x), 322);
        check("f1_ball_y", int'(ball_y), 242);
        check("f1_pad_y", int'(pad_y), 204);
        check("f1_hit", nh + nm, 0);

        // Paddle runs down to 408 while the ball climbs, bounces off the bottom and nears the paddle.
        btn_down = 1'b1;
        th = 0;
        tm = 0;
        for (int k = 2; k <= 136; k++) begin
            frame(0, nb, nh, nm);
            th += nh;
            tm += nm;
            if (k == 52) check("pad_dn_max", int'(pad_y), 408);
            if (k == 53) check("pad_dn_hold", int'(pad_y), 408);
            if (k == 116) check("bot_bounce_y", int'(ball_y), 472);
            if (k == 117) check("after_bot_y", int'(ball_y), 470);
        end
        check("pre_hit_hits", th, 0);
        check("pre_hit_misses", tm, 0);
        check("k136_ball_x", int'(ball_x), 592);
        check("k136_ball_y", int'(ball_y), 432);

        frame(0, nb, nh, nm);
        check("hit_pulse", nh, 1);
        check("hit_no_miss", nm, 0);
        check("hit_busy_clks", nb, 3);
        check("hit_ball_x", int'(ball_x), 594);
        check("hit_ball_y", int'(ball_y), 430);

        frame(0, nb, nh, nm);
        check("after_hit_x", int'(ball_x), 592);
        check("after_hit_y", int'(ball_y), 428);
        check("after_hit_pulse", nh, 0);

        // Ball travels up-left: top bounce at y=0, wall bounce at x=34.
        th = 0;
        tm = 0;
        for (int m = 1; m <= 280; m++) begin
            frame(0, nb, nh, nm);
            th += nh;
            tm += nm;
            if (m == 214) begin
                check("top_x", int'(ball_x), 164);
                check("top_y", int'(ball_y), 0);
            end
            if (m == 215) check("after_top_y", int'(ball_y), 2);
            if (m == 279) begin
                check("wall_x", int'(ball_x), 34);
                check("wall_y", int'(ball_y), 130);
            end
            if (m == 280) check("after_wall_x", int'(ball_x), 36);
        end
        check("return_hits", th, 0);
        check("return_misses", tm, 0);

        // Second instance: paddle up clamp, then a miss with the paddle parked at the top.
        btn2_up = 1'b1;
        frame(1, nb, nh, nm);
        check("u2_pad_f1", int'(pad_y2), 2);
        frame(1, nb, nh, nm);
        check("u2_pad_clamp", int'(pad_y2), 0);
        frame(1, nb, nh, nm);
        check("u2_pad_hold", int'(pad_y2), 0);
        check("u2_ball_x3", int'(ball_x2), 326);
        th = 0;
        tm = 0;
        for (int k = 4; k <= 156; k++) begin
            frame(1, nb, nh, nm);
            th += nh;
            tm += nm;
        end
        check("u2_pre_miss_hits", th, 0);
        check("u2_pre_miss_misses", tm, 0);
        check("u2_k156_x", int'(ball_x2), 632);
        check("u2_k156_y", int'(ball_y2), 392);

        frame(1, nb, nh, nm);
        check("miss_pulse", nm, 1);
        check("miss_no_hit", nh, 0);
        check("miss_ball_x", int'(ball_x2), 320);
        check("miss_ball_y", int'(ball_y2), 240);
        check("miss_cnt", int'(miss_cnt2), ExpMissCnt);

        pix(324, 244, 1'b1, "rgb_ball", 12'hF00);
        @(negedge clk);
        pixel_x = 10'd100;
        pixel_y = 10'd100;
        @(negedge clk);
        check("rgb_hold", int'(rgb2), 12'hF00);
        pix(324, 244, 1'b0, "rgb_blank", 12'h000);
        pix(601, 10, 1'b1, "rgb_pad", 12'h0F0);
        pix(601, 72, 1'b1, "rgb_below_pad", 12'hFFF);
        pix(33, 300, 1'b1, "rgb_wall", 12'h00F);
        pix(36, 300, 1'b1, "rgb_right_of_wall", 12'hFFF);
        pix(327, 247, 1'b1, "rgb_ball_corner", 12'hF00);
        pix(328, 247, 1'b1, "rgb_past_ball", 12'hFFF);

        btn2_up = 1'b0;
        btn2_down = 1'b1;
        frame(1, nb, nh, nm);
        check("u2_restart_x", int'(ball_x2), 322);
        check("u2_restart_y", int'(ball_y2), 242);
        check("u2_pad_dn1", int'(pad_y2), 202);
        frame(1, nb, nh, nm);
        check("u2_pad_dn2", int'(pad_y2), 404);
        frame(1, nb, nh, nm);
        check("u2_pad_dn_clamp", int'(pad_y2), 408);
        btn2_up = 1'b1;
        frame(1, nb, nh, nm);
        check("u2_pad_both", int'(pad_y2), 408);

        // Reset landing in the BALL state abandons the update.
        @(negedge clk);
        pixel_x = 10'd0;
        pixel_y = 10'd481;
        video_on = 1'b0;
        p_tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", int'(busy), 1);
        reset = 1'b1;
        p_tick = 1'b0;
        @(negedge clk);
        check("mid_rst_ball_x", int'(ball_x), 320);
        check("mid_rst_ball_y", int'(ball_y), 240);
        check("mid_rst_pad_y", int'(pad_y), 204);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_miss_cnt", int'(miss_cnt), 0);
        reset = 1'b0;
        nb = 0;
        nh = 0;
        nm = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nb += int'(busy);
            nh += int'(hit);
            nm += int'(miss);
        end
        check("post_rst_busy", nb, 0);
        check("post_rst_pulses", nh + nm, 0);
        check("post_rst_ball_x", int'(ball_x), 320);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
